// File: rtl/stage_reg_elastic.sv
// stage_reg_elastic
//   Two-entry elastic pipeline stage with order tagging and flush rewind.
//   MAIN drives the outputs; SKID catches the single beat that can arrive
//   while MAIN is stalled. Every output is decoded from flops only, so there
//   is no combinational path from the in_* side to the out_* side.
//
//   Ports
//     clk        : clock, all state changes on its rising edge
//     rst_n      : asynchronous active-low reset
//     in_valid   : upstream beat present
//     in_ready   : stage can accept a beat this cycle (SKID empty)
//     in_data    : upstream payload
//     flush      : discard all held beats, block accept this cycle
//     out_valid  : downstream beat present (MAIN valid)
//     out_ready  : downstream accepts beat
//     out_data   : payload of oldest held beat
//     out_order  : order tag of oldest held beat
//     occupancy  : number of held beats, 0..2
//
//   state    | meaning
//   ---------+-----------------------------------------
//   ST_EMPTY | nothing held
//   ST_ONE   | MAIN holds a beat, SKID empty
//   ST_FULL  | MAIN and SKID both hold beats
module stage_reg_elastic #(
    parameter int DATA_W  = 129,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [ORDER_W-1:0] out_order,
    output logic [1:0]         occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic [ORDER_W-1:0] main_order_q, main_order_d;
    logic [ORDER_W-1:0] skid_order_q, skid_order_d;
    logic [ORDER_W-1:0] order_cnt_q, order_cnt_d;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic pop;

    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_FULL);

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign out_order = main_order_q;
    assign occupancy = state_q;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            main_order_q <= '0;
            skid_order_q <= '0;
            order_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            main_order_q <= main_order_d;
            skid_order_q <= skid_order_d;
            order_cnt_q  <= order_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        main_order_d = main_order_q;
        skid_order_d = skid_order_q;
        order_cnt_d  = order_cnt_q;

        if (flush) begin
            state_d = ST_EMPTY;
            // Rewind to the oldest beat that is being thrown away. A beat
            // popped in the same cycle was delivered, so its tag is kept.
            if (main_valid && !pop) begin
                order_cnt_d = main_order_q;
            end else if (skid_valid) begin
                order_cnt_d = skid_order_q;
            end
        end else begin
            if (accept) begin
                order_cnt_d = order_cnt_q + ORDER_W'(1);
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        main_data_d  = in_data;
                        main_order_d = order_cnt_q;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_data_d  = in_data;
                        main_order_d = order_cnt_q;
                    end else if (accept) begin
                        state_d      = ST_FULL;
                        skid_data_d  = in_data;
                        skid_order_d = order_cnt_q;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d      = ST_ONE;
                        main_data_d  = skid_data_q;
                        main_order_d = skid_order_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_reg_elastic.sv
// tb_stage_reg_elastic
//   Directed bench for stage_reg_elastic with a 4-bit order tag so that
//   tag wrap is reachable in a short run.
module tb_stage_reg_elastic;

    localparam int DW = 129;
    localparam int OW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [OW-1:0] out_order;
    logic [1:0]    occupancy;

    int tests = 0;
    int fails = 0;

    stage_reg_elastic #(.DATA_W(DW), .ORDER_W(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_order (out_order),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid  = 1'b1;
        in_data   = DW'(8'h5A);
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        tick();
        // Held in reset across an edge with in_valid high: nothing accepted.
        tests++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %0b want 0", out_valid); fails++; end
        tests++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %0b want 1", in_ready); fails++; end
        tests++; if (occupancy !== 2'd0) begin $display("FAIL reset_occupancy: got %0d want 0", occupancy); fails++; end
        tests++; if (out_order !== 4'd0) begin $display("FAIL reset_out_order: got %0d want 0", out_order); fails++; end
        tests++; if (out_data !== '0) begin $display("FAIL reset_out_data: got %0h want 0", out_data); fails++; end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // First rising edge after release accepts the beat.
        tests++; if (occupancy !== 2'd1) begin $display("FAIL release_occupancy: got %0d want 1", occupancy); fails++; end
        tests++; if (out_data !== DW'(8'h5A)) begin $display("FAIL release_out_data: got %0h want 5a", out_data); fails++; end
        tests++; if (out_order !== 4'd0) begin $display("FAIL release_out_order: got %0d want 0", out_order); fails++; end
        in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
            tests++; if (out_valid !== 1'b1) begin $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); fails++; end
            tests++; if (out_data !== DW'(i)) begin $display("FAIL stream_data[%0d]: got %0d want %0d", i, out_data, i); fails++; end
            tests++; if (out_order !== OW'(i)) begin $display("FAIL stream_order[%0d]: got %0d want %0d", i, out_order, i); fails++; end
            tests++; if (in_ready !== 1'b1) begin $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, in_ready); fails++; end
            tests++; if (occupancy !== 2'd1) begin $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); fails++; end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (occupancy !== 2'd0) begin $display("FAIL stream_drain_occ: got %0d want 0", occupancy); fails++; end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(8'hA1);
        tick();
        in_data = DW'(8'hB2);
        tick();
        in_valid = 1'b0;
        tests++; if (occupancy !== 2'd2) begin $display("FAIL bp_occ_full: got %0d want 2", occupancy); fails++; end
        tests++; if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready_full: got %0b want 0", in_ready); fails++; end
        tests++; if (out_data !== DW'(8'hA1)) begin $display("FAIL bp_head_a: got %0h want a1", out_data); fails++; end
        // Offer a beat while full: must be ignored, contents unchanged.
        in_valid = 1'b1;
        in_data  = DW'(8'hCC);
        tick();
        in_valid = 1'b0;
        tests++; if (out_data !== DW'(8'hA1) || occupancy !== 2'd2) begin $display("FAIL bp_hold: got data %0h occ %0d want a1 occ 2", out_data, occupancy); fails++; end
        tests++; if (out_order !== 4'd0) begin $display("FAIL bp_hold_order: got %0d want 0", out_order); fails++; end
        out_ready = 1'b1;
        tick();
        tests++; if (out_data !== DW'(8'hB2)) begin $display("FAIL bp_head_b: got %0h want b2", out_data); fails++; end
        tests++; if (out_order !== 4'd1) begin $display("FAIL bp_order_b: got %0d want 1", out_order); fails++; end
        tests++; if (in_ready !== 1'b1) begin $display("FAIL bp_in_ready_back: got %0b want 1", in_ready); fails++; end
        tests++; if (occupancy !== 2'd1) begin $display("FAIL bp_occ_one: got %0d want 1", occupancy); fails++; end
        tick();
        tests++; if (out_valid !== 1'b0) begin $display("FAIL bp_drain: got %0b want 0", out_valid); fails++; end
    endtask

    task automatic test_flush_rewind();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'h100 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(16'h103);
        tick();
        in_data = DW'(16'h104);
        tick();
        tests++; if (occupancy !== 2'd2 || out_order !== 4'd3) begin $display("FAIL fr_full: got occ %0d order %0d want occ 2 order 3", occupancy, out_order); fails++; end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (occupancy !== 2'd0) begin $display("FAIL fr_occ: got %0d want 0", occupancy); fails++; end
        tests++; if (out_valid !== 1'b0) begin $display("FAIL fr_valid: got %0b want 0", out_valid); fails++; end
        in_data = DW'(16'h1F0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_order !== 4'd3) begin $display("FAIL fr_retag: got %0d want 3", out_order); fails++; end
        tests++; if (out_data !== DW'(16'h1F0)) begin $display("FAIL fr_data: got %0h want 1f0", out_data); fails++; end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush_pop();
        // Next tag is 4 on entry; consume it so the stage holds tags 5,6.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(16'h204);
        tick();
        tests++; if (out_order !== 4'd4) begin $display("FAIL fp_tag4: got %0d want 4", out_order); fails++; end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(16'h205);
        tick();
        in_data = DW'(16'h206);
        tick();
        tests++; if (occupancy !== 2'd2 || out_order !== 4'd5) begin $display("FAIL fp_full: got occ %0d order %0d want occ 2 order 5", occupancy, out_order); fails++; end
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (occupancy !== 2'd0) begin $display("FAIL fp_occ: got %0d want 0", occupancy); fails++; end
        tests++; if (in_ready !== 1'b1) begin $display("FAIL fp_in_ready: got %0b want 1", in_ready); fails++; end
        in_data = DW'(16'h2E0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_order !== 4'd6) begin $display("FAIL fp_retag: got %0d want 6", out_order); fails++; end
        tick();
        // Flush while empty with in_valid high: blocks accept, tag unchanged.
        in_valid = 1'b1;
        in_data  = DW'(16'h2E1);
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (occupancy !== 2'd0) begin $display("FAIL fe_occ: got %0d want 0", occupancy); fails++; end
        tick();
        in_valid = 1'b0;
        tests++; if (out_order !== 4'd7) begin $display("FAIL fe_tag: got %0d want 7", out_order); fails++; end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
            tests++; if (out_order !== OW'(i % 16)) begin $display("FAIL wrap_order[%0d]: got %0d want %0d", i, out_order, i % 16); fails++; end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'h300 + i);
            tick();
        end
        out_ready = 1'b0;
        in_data   = DW'(16'h303);
        tick();
        in_valid = 1'b0;
        tests++; if (occupancy !== 2'd2) begin $display("FAIL ar_pre_occ: got %0d want 2", occupancy); fails++; end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin $display("FAIL ar_out_valid: got %0b want 0", out_valid); fails++; end
        tests++; if (in_ready !== 1'b1) begin $display("FAIL ar_in_ready: got %0b want 1", in_ready); fails++; end
        tests++; if (occupancy !== 2'd0) begin $display("FAIL ar_occ: got %0d want 0", occupancy); fails++; end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(16'h377);
        tick();
        in_valid = 1'b0;
        tests++; if (out_order !== 4'd0) begin $display("FAIL ar_first_tag: got %0d want 0", out_order); fails++; end
        tests++; if (out_data !== DW'(16'h377)) begin $display("FAIL ar_first_data: got %0h want 377", out_data); fails++; end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_rewind();
        test_flush_pop();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage_reg_elastic.md
STAGE_REG_ELASTIC -- requirements
Module: stage_reg_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 129, payload width in bits (inst 32 + pc 32 + order-free control fields).
REQ-002 SHALL have parameter ORDER_W, default 64, instruction order-tag width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream beat present.
REQ-006 SHALL have port in_ready  output  1  stage can accept a beat this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port flush  input  1  discard all held beats (branch redirect).
REQ-009 SHALL have port out_valid  output  1  downstream beat present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-011 SHALL have port out_data  output  DATA_W  payload of oldest held beat.
REQ-012 SHALL have port out_order  output  ORDER_W  order tag of oldest held beat.
REQ-013 SHALL have port occupancy  output  2  number of held beats (0..2).

Function
REQ-014 SHALL hold two entries, MAIN (drives outputs) and SKID, each with valid, data, order tag; all outputs driven from flops only (no in_* to out_* combinational path).
REQ-015 SHALL drive in_ready = NOT SKID.valid; out_valid = MAIN.valid; out_data/out_order = MAIN fields; occupancy = MAIN.valid + SKID.valid.
REQ-016 SHALL define accept = in_valid AND in_ready AND NOT flush; pop = out_valid AND out_ready.
REQ-017 SHALL maintain state EMPTY (occ 0), ONE (MAIN only), FULL (MAIN+SKID); SKID valid with MAIN invalid is illegal.
REQ-018 EMPTY: accept -> ONE, beat into MAIN; else stay.
REQ-019 ONE: accept and pop -> ONE, new beat into MAIN; accept only -> FULL, beat into SKID; pop only -> EMPTY; neither -> stay.
REQ-020 FULL: pop -> ONE, SKID moves to MAIN; no accept possible (in_ready=0); no pop -> stay.
REQ-021 SHALL give latency of one cycle: beat accepted at edge N is on out_* after edge N when stage was EMPTY or ONE-with-pop.
REQ-022 SHALL sustain one beat per cycle when out_ready held high; MAIN/SKID contents never change while held and not popped.
REQ-023 SHALL hold internal counter order_cnt (ORDER_W bits); each accepted beat is tagged with order_cnt, then order_cnt increments by 1, wrapping modulo 2^ORDER_W.
REQ-024 flush SHALL clear MAIN.valid and SKID.valid at the next edge and block accept that cycle, regardless of in_valid.
REQ-025 On flush, order_cnt SHALL rewind to the tag of the oldest discarded beat: MAIN.order if MAIN valid and not popped; else SKID.order if SKID valid; else unchanged.
REQ-026 A pop coincident with flush SHALL count as consumed (downstream handshake stands); that beat's tag is not reused.
REQ-027 flush while EMPTY SHALL be a no-op apart from blocking accept.
REQ-028 Tags on out_order SHALL be strictly consecutive (mod 2^ORDER_W) across pops with no intervening flush.

Reset
REQ-029 While rst_n low: MAIN.valid=0, SKID.valid=0, order_cnt=0; hence out_valid=0, in_ready=1, occupancy=0, out_order=0, out_data=0.
REQ-030 Reset SHALL take effect asynchronously on rst_n fall, mid-transfer included; held beats are discarded, not delivered.
REQ-031 Release SHALL be synchronous-safe: first accept possible at first rising edge with rst_n high.

Verification
REQ-032 Streaming: out_ready=1, 10 beats in_data=0..9 back-to-back -> out_data 0..9 on consecutive cycles, out_order 0..9, in_ready stays 1, occupancy never 2.
REQ-033 Backpressure: out_ready=0, feed A,B -> occupancy 2, in_ready=0, out_data=A held; raise out_ready -> A then B, in_ready returns 1 the cycle after A pops.
REQ-034 Flush rewind: tags 0..4 issued, FULL holding 3,4, out_ready=0, flush=1 -> next cycle occupancy 0; next accepted beat tagged 3.
REQ-035 Flush with pop: FULL holding 5,6, out_ready=1, flush=1 -> beat 5 consumed, 6 dropped; next accepted beat tagged 6.
REQ-036 Wrap: ORDER_W=4, stream 18 beats -> out_order 0..15,0,1.
REQ-037 Async reset: rst_n low mid-stream between edges -> out_valid=0 and in_ready=1 immediately; after release first beat tagged 0.
